// File: rtl/imem_load_pkg.sv
// Shared types and default geometry for the instruction-memory loader.
// Optional build macro: IMEM_LOAD_CHECKSUM_EN.
package imem_load_pkg;

   localparam int ADDR_W_DEF = 12;
   localparam int WORD_W_DEF = 32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HDR   = 3'd1,
      ST_DATA  = 3'd2,
      ST_CKSUM = 3'd3,
      ST_ERR   = 3'd4
   } state_e;

endpackage

// File: rtl/imem_load_if.sv
// Single-port memory write bundle (we/addr/wdata).
// master drives the port, slave receives it.
interface imem_load_if #(
   parameter int ADDR_W = 12,
   parameter int WORD_W = 32
);

   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [WORD_W-1:0] wdata;

   modport master (output we, addr, wdata);
   modport slave  (input  we, addr, wdata);

endinterface

// File: rtl/imem_load_word_shifter.sv
// Serial-to-parallel word assembler, LSB first.
// word_done pulses the cycle after the WORD_W-th accepted bit.
module word_shifter #(
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              en,
   input  logic              bit_in,
   output logic [WORD_W-1:0] word,
   output logic              word_done
);

   localparam int CNT_W = $clog2(WORD_W);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W - 1);

   logic [WORD_W-1:0] sr_q, sr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              done_q, done_d;

   always_comb begin
      sr_d   = sr_q;
      cnt_d  = cnt_q;
      done_d = 1'b0;
      if (clr) begin
         sr_d  = '0;
         cnt_d = '0;
      end else if (en) begin
         sr_d = {bit_in, sr_q[WORD_W-1:1]};
         if (cnt_q == LAST) begin
            cnt_d  = '0;
            done_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr_q   <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         sr_q   <= sr_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign word      = sr_q;
   assign word_done = done_q;

endmodule

// File: rtl/imem_load_ctrl.sv
// Serial instruction-memory loader with CPU write arbitration.
// Define IMEM_LOAD_CHECKSUM_EN to require a trailing sum word.
module imem_load_ctrl
   import imem_load_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int WORD_W = WORD_W_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        bit_valid,
   input  logic        bit_in,
   input  logic        load_start,
   imem_load_if.slave  cpu,
   imem_load_if.master mem,
   output logic        cpu_hold,
   output logic        load_busy,
   output logic        load_done,
   output logic        load_err
);

   localparam logic [2:0] S_IDLE  = 3'(ST_IDLE);
   localparam logic [2:0] S_HDR   = 3'(ST_HDR);
   localparam logic [2:0] S_DATA  = 3'(ST_DATA);
   localparam logic [2:0] S_CKSUM = 3'(ST_CKSUM);
   localparam logic [2:0] S_ERR   = 3'(ST_ERR);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
   logic [WORD_W-1:0] sum_q, sum_d;
`endif

   logic [WORD_W-1:0] word;
   logic              word_done;
   logic              wr;
   logic [ADDR_W-1:0] idx_nx;

   assign load_busy = (state_q == S_HDR) || (state_q == S_DATA) ||
                      (state_q == S_CKSUM);
   assign cpu_hold  = (state_q != S_IDLE);
   assign load_done = done_q;
   assign load_err  = err_q;
   assign wr        = (state_q == S_DATA) && word_done;
   assign idx_nx    = idx_q + ADDR_W'(1);

   word_shifter #(.WORD_W(WORD_W)) u_shift (
      .clk       (clk),
      .reset     (reset),
      .clr       (load_start),
      .en        (bit_valid && load_busy && !load_start),
      .bit_in    (bit_in),
      .word      (word),
      .word_done (word_done)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      done_d  = done_q;
      err_d   = err_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      if (load_start) begin
         state_d = S_HDR;
         idx_d   = '0;
         done_d  = 1'b0;
         err_d   = 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
         sum_d   = '0;
`endif
      end else if (word_done) begin
         case (state_q)
            S_HDR: begin
               if (|word[WORD_W-1:ADDR_W]) begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end else if (word == '0) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                  state_d = S_CKSUM;
`else
                  state_d = S_IDLE;
                  done_d  = 1'b1;
`endif
               end else begin
                  len_d   = word[ADDR_W-1:0];
                  state_d = S_DATA;
               end
            end
            S_DATA: begin
               idx_d = idx_nx;
`ifdef IMEM_LOAD_CHECKSUM_EN
               sum_d = sum_q + word;
`endif
               if (idx_nx == len_q) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                  state_d = S_CKSUM;
`else
                  state_d = S_IDLE;
                  done_d  = 1'b1;
`endif
               end
            end
`ifdef IMEM_LOAD_CHECKSUM_EN
            S_CKSUM: begin
               if (word == sum_q) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

`ifdef IMEM_LOAD_CHECKSUM_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sum_q <= '0;
      else        sum_q <= sum_d;
   end
`endif

   // Outside IDLE the CPU is held, so its writes are simply dropped.
   always_comb begin
      if (state_q == S_IDLE) begin
         mem.we    = cpu.we;
         mem.addr  = cpu.addr;
         mem.wdata = cpu.wdata;
      end else begin
         mem.we    = wr;
         mem.addr  = idx_q;
         mem.wdata = word;
      end
   end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl (ADDR_W=12, WORD_W=32).
// Checksum vectors run when IMEM_LOAD_CHECKSUM_EN is defined.
module tb_imem_load_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic bit_valid = 1'b0;
   logic bit_in = 1'b0;
   logic load_start = 1'b0;
   logic cpu_hold, load_busy, load_done, load_err;

   imem_load_if #(.ADDR_W(12), .WORD_W(32)) cpu_if ();
   imem_load_if #(.ADDR_W(12), .WORD_W(32)) mem_if ();

   imem_load_ctrl #(.ADDR_W(12), .WORD_W(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .bit_valid  (bit_valid),
      .bit_in     (bit_in),
      .load_start (load_start),
      .cpu        (cpu_if),
      .mem        (mem_if),
      .cpu_hold   (cpu_hold),
      .load_busy  (load_busy),
      .load_done  (load_done),
      .load_err   (load_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int nwr = 0;
   int last_wr = -1;
   int hold_fall = -1;
   logic hold_prev = 1'b0;
   logic [11:0] wa [64];
   logic [31:0] wd [64];

   always @(posedge clk) cyc <= cyc + 1;

   // Loader writes are the only ones that may appear while held.
   always @(negedge clk) begin
      if (mem_if.we && cpu_hold) begin
         if (nwr < 64) begin
            wa[nwr] = mem_if.addr;
            wd[nwr] = mem_if.wdata;
         end
         nwr++;
         last_wr = cyc;
      end
      if (hold_prev && !cpu_hold) hold_fall = cyc;
      hold_prev = cpu_hold;
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic send_bit(input logic b, input int gap);
      bit_valid = 1'b1;
      bit_in    = b;
      tick();
      bit_valid = 1'b0;
      for (int g = 1; g < gap; g++) tick();
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int i = 0; i < 32; i++) send_bit(w[i], gap);
   endtask

   int base;

   initial begin
      cpu_if.we    = 1'b0;
      cpu_if.addr  = '0;
      cpu_if.wdata = '0;

      // reset state
      repeat (3) tick();
      chk("rst_hold", cpu_hold, 0);
      chk("rst_busy", load_busy, 0);
      chk("rst_done", load_done, 0);
      chk("rst_err", load_err, 0);
      chk("rst_we", mem_if.we, 0);
      reset = 1'b1;
      tick();

      // idle passthrough
      cpu_if.we    = 1'b1;
      cpu_if.addr  = 12'h005;
      cpu_if.wdata = 32'hDEADBEEF;
      #1;
      chk("pt_we", mem_if.we, 1);
      chk("pt_addr", mem_if.addr, 12'h005);
      chk("pt_data", mem_if.wdata, 32'hDEADBEEF);
      chk("pt_hold", cpu_hold, 0);
      bit_valid = 1'b1;
      tick();
      bit_valid = 1'b0;
      chk("idle_busy", load_busy, 0);

      // N=3, one bit every 4 cycles, cpu_we kept high throughout
      cpu_if.wdata = 32'h0BAD0BAD;
      cpu_if.addr  = 12'h007;
      base = nwr;
      start();
      chk("s1_busy", load_busy, 1);
      chk("s1_hold", cpu_hold, 1);
      send_word(32'd3, 4);
      send_word(32'h11111111, 4);
      send_word(32'h22222222, 4);
      send_word(32'h33333333, 4);
`ifdef IMEM_LOAD_CHECKSUM_EN
      send_word(32'h66666666, 4);
`endif
      repeat (3) tick();
      chk("s1_nwr", nwr - base, 3);
      chk("s1_a0", wa[base], 12'd0);
      chk("s1_a1", wa[base+1], 12'd1);
      chk("s1_a2", wa[base+2], 12'd2);
      chk("s1_d0", wd[base], 32'h11111111);
      chk("s1_d1", wd[base+1], 32'h22222222);
      chk("s1_d2", wd[base+2], 32'h33333333);
`ifndef IMEM_LOAD_CHECKSUM_EN
      chk("s1_fall", hold_fall - last_wr, 1);
`endif
      chk("s1_done", load_done, 1);
      chk("s1_hold_end", cpu_hold, 0);
      chk("s1_busy_end", load_busy, 0);
      repeat (4) tick();
      chk("s1_sticky", load_done, 1);

      // back-to-back bits, N=2
      cpu_if.we = 1'b0;
      base = nwr;
      start();
      chk("s2_done_clr", load_done, 0);
      send_word(32'd2, 1);
      send_word(32'hA5A50F0F, 1);
      send_word(32'h12345678, 1);
`ifdef IMEM_LOAD_CHECKSUM_EN
      send_word(32'hB7D96587, 1);
`endif
      repeat (3) tick();
      chk("s2_nwr", nwr - base, 2);
      chk("s2_a1", wa[base+1], 12'd1);
      chk("s2_d0", wd[base], 32'hA5A50F0F);
      chk("s2_d1", wd[base+1], 32'h12345678);
      chk("s2_done", load_done, 1);

      // empty image
      start();
      send_word(32'd0, 1);
`ifdef IMEM_LOAD_CHECKSUM_EN
      send_word(32'd0, 1);
`endif
      repeat (2) tick();
      chk("n0_done", load_done, 1);
      chk("n0_busy", load_busy, 0);

      // oversize header
      cpu_if.we = 1'b1;
      base = nwr;
      start();
      send_word(32'h00001000, 1);
      repeat (3) tick();
      chk("er_err", load_err, 1);
      chk("er_hold", cpu_hold, 1);
      chk("er_busy", load_busy, 0);
      chk("er_done", load_done, 0);
      chk("er_nwr", nwr - base, 0);
      start();
      chk("er_clr", load_err, 0);
      chk("er_rebusy", load_busy, 1);

      // reset 17 bits into data word 0
      cpu_if.we = 1'b0;
      send_word(32'd2, 1);
      for (int i = 0; i < 17; i++) send_bit(1'b1, 1);
      reset = 1'b0;
      #1;
      chk("mr_hold", cpu_hold, 0);
      chk("mr_busy", load_busy, 0);
      chk("mr_done", load_done, 0);
      chk("mr_err", load_err, 0);
      chk("mr_we", mem_if.we, 0);
      tick();
      reset = 1'b1;
      tick();
      base = nwr;
      start();
      send_word(32'd1, 1);
      send_word(32'hCAFEF00D, 1);
`ifdef IMEM_LOAD_CHECKSUM_EN
      send_word(32'hCAFEF00D, 1);
`endif
      repeat (3) tick();
      chk("mr_nwr", nwr - base, 1);
      chk("mr_a0", wa[base], 12'd0);
      chk("mr_d0", wd[base], 32'hCAFEF00D);
      chk("mr_done2", load_done, 1);

`ifdef IMEM_LOAD_CHECKSUM_EN
      // checksum match and mismatch
      start();
      send_word(32'd2, 1);
      send_word(32'h1, 1);
      send_word(32'h2, 1);
      send_word(32'h3, 1);
      repeat (3) tick();
      chk("ck_done", load_done, 1);
      chk("ck_err", load_err, 0);
      start();
      send_word(32'd2, 1);
      send_word(32'h1, 1);
      send_word(32'h2, 1);
      send_word(32'h4, 1);
      repeat (3) tick();
      chk("ck_bad_err", load_err, 1);
      chk("ck_bad_hold", cpu_hold, 1);
      chk("ck_bad_done", load_done, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
